// File: rtl/rr_chan_merge_pkg.sv
// Shared constants and helpers for the round-robin channel merge.
// No logic, no latency.
// No handshakes; used at elaboration time only.
package rr_merge_pkg;

  // Smallest legal parameter values for the merge block.
  localparam int MIN_NCH   = 1;
  localparam int MIN_DW    = 1;
  localparam int MIN_DEPTH = 2;

  // Channel-index width; a single channel still needs one bit to carry a tag.
  function automatic int cw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy counter width, wide enough to hold the value DEPTH itself.
  function automatic int cntw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // FIFO pointers wrap naturally only when the depth is a power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/rr_chan_merge_if.sv
// Bundle of the per-channel input handshakes and the merged output stream.
// Pure wiring, no latency.
// Carries valid/ready in both directions; the block owns in_ready and out_*.
interface rr_chan_merge_if #(
  parameter int NCH   = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 2
);
  import rr_merge_pkg::*;

  localparam int CW   = cw(NCH);
  localparam int CNTW = cntw(DEPTH);

  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0][DW-1:0] in_data;
  logic [NCH-1:0]         in_ready;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [CW-1:0]          out_chan;
  logic                   out_ready;
  logic [CNTW-1:0]        count;

  // The merge block itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, count
  );

  // Producers and consumer around the block.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, count
  );

endinterface

// File: rtl/rr_chan_merge_fifo.sv
// Generic synchronous FIFO of W-bit records with a registered head.
// Push at edge k is visible at o_head after edge k when empty.
// Push is ignored when full unless a pop frees a slot in the same cycle; pop on empty is ignored.
module rr_merge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_dat,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNTW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // When full, the slot being popped this cycle is the one written next edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage and wrapping read/write pointers; storage is cleared so the head is never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_dat;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rr_chan_merge.sv
// Round-robin merge of NCH valid/ready channels into one channel-tagged stream.
// One cycle from accept to out_* when the FIFO is empty; strict FIFO order otherwise.
// in_ready is one-hot to the arbiter winner when a slot is free (or freed by a pop), else all zero.
module rr_chan_merge #(
  parameter int NCH   = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  rr_chan_merge_if.slave bus
);
  import rr_merge_pkg::*;

  localparam int CW   = cw(NCH);
  localparam int CNTW = cntw(DEPTH);

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [DW-1:0] data;
  } rec_t;

  if (NCH < MIN_NCH) begin : g_bad_nch
    $error("rr_chan_merge: NCH must be at least 1");
  end
  if (DW < MIN_DW) begin : g_bad_dw
    $error("rr_chan_merge: DW must be at least 1");
  end
  if ((DEPTH < MIN_DEPTH) || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("rr_chan_merge: DEPTH must be a power of two, at least 2");
  end

  logic [CW-1:0]   r_ptr;

  logic            w_hit_hi;
  logic            w_hit_lo;
  logic [CW-1:0]   w_idx_hi;
  logic [CW-1:0]   w_idx_lo;
  logic [CW-1:0]   w_gnt;
  logic [DW-1:0]   w_gnt_dat;
  logic            w_found;
  logic            w_pop;
  logic            w_can_push;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [NCH-1:0]  w_ready;
  logic [CNTW-1:0] w_count;
  rec_t            w_push_rec;
  rec_t            w_head;

  // Search for the first valid channel at or above r_ptr, falling back to the lowest valid one;
  // the descending scan leaves the smallest matching index in each result.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        w_hit_lo = 1'b1;
        w_idx_lo = CW'(i);
        if (i >= int'(r_ptr)) begin
          w_hit_hi = 1'b1;
          w_idx_hi = CW'(i);
        end
      end
    end
  end

  assign w_found    = w_hit_lo;
  assign w_gnt      = w_hit_hi ? w_idx_hi : w_idx_lo;
  assign w_pop      = !w_empty && bus.out_ready;
  assign w_can_push = !w_full || w_pop;
  assign w_push     = w_found && w_can_push;

  // Select the winner's data for the pushed record.
  always_comb begin
    w_gnt_dat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (CW'(i) == w_gnt) begin
        w_gnt_dat = bus.in_data[i];
      end
    end
  end

  // Only the winner sees ready, and only when its beat can be stored this cycle.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ready[i] = w_push && (CW'(i) == w_gnt);
    end
  end

  // Advance priority past the channel that just transferred; blocked grants leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_push) begin
      r_ptr <= (int'(w_gnt) == NCH - 1) ? '0 : w_gnt + 1'b1;
    end
  end

  assign w_push_rec = '{chan: w_gnt, data: w_gnt_dat};

  rr_merge_fifo #(
    .W     ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (w_push_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head.data;
  assign bus.out_chan  = w_head.chan;
  assign bus.count     = w_count;

endmodule
